// File: rtl/machine_pkg.sv
// Shared types and constants for the Machine block.
// Opcode encoding, data width and default history depth.
package machine_pkg;
  localparam int WORD_W = 2;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_UNDO = 2'd3
  } op_e;
endpackage

// File: rtl/machine_if.sv
// Opcode/result bus between the driver and the accumulator machine.
// Master drives the opcode, slave returns the accumulator.
interface machine_if;
  import machine_pkg::*;
  logic [WORD_W-1:0] x;
  logic [WORD_W-1:0] result;

  modport master (output x, input result);
  modport slave (input x, output result);
endinterface

// File: rtl/machine_history.sv
// Bounded LIFO of past accumulator values.
// Pushing while full drops the oldest entry.
module machine_history
  import machine_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_cnt;
  logic              w_empty;
  logic              w_full;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = w_empty;
  assign o_full  = w_full;

  always_comb begin
    o_top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_cnt == CW'(i + 1))
        o_top = r_mem[i];
  end

  // Entry 0 is the oldest; the top sits at r_cnt-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_push) begin
      if (w_full) begin
        for (int i = 0; i < DEPTH - 1; i++)
          r_mem[i] <= r_mem[i+1];
        r_mem[DEPTH-1] <= i_data;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (r_cnt == CW'(i))
            r_mem[i] <= i_data;
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (i_pop && !w_empty) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/machine_top_entity.sv
// Two-bit accumulator with INC/DEC/UNDO and a bounded undo history.
// result is registered; x reaches it only through the edge.
module machine_top_entity
  import machine_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  machine_if.slave bus
);
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] w_nxt;
  logic [WORD_W-1:0] w_top;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  op_e               w_op;

  assign w_op = op_e'(bus.x);

  always_comb begin
    w_nxt  = r_acc;
    w_push = 1'b0;
    w_pop  = 1'b0;
    unique case (1'b1)
      (w_op == OP_HOLD): ;
      (w_op == OP_INC): begin
        w_push = 1'b1;
        w_nxt  = r_acc + WORD_W'(1);
      end
      (w_op == OP_DEC): begin
        w_push = 1'b1;
        w_nxt  = r_acc - WORD_W'(1);
      end
      (w_op == OP_UNDO): begin
        w_pop = 1'b1;
        if (!w_empty)
          w_nxt = w_top;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_acc <= '0;
    else
      r_acc <= w_nxt;
  end

  assign bus.result = r_acc;

  machine_history #(
    .DEPTH(DEPTH)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (r_acc),
    .o_top  (w_top),
    .o_empty(w_empty),
    .o_full (w_full)
  );
endmodule

// File: tb/tb_machine_top_entity.sv
// Scoreboard bench for machine_top_entity.
// Directed plan sequences, then random ops against a queue model.
module tb_machine_top_entity;
  import machine_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  logic [1:0] sb [$];
  logic [1:0] m_acc = 2'd0;
  logic [1:0] m_hist [$];

  machine_if bus ();

  machine_top_entity #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got,
                     input logic [1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour using a plain SV queue as the history.
  function automatic logic [1:0] model(input logic r, input logic [1:0] op);
    if (r) begin
      m_acc = 2'd0;
      m_hist.delete();
    end else begin
      case (op)
        2'd1: begin
          if (m_hist.size() == DEPTH) void'(m_hist.pop_front());
          m_hist.push_back(m_acc);
          m_acc = m_acc + 2'd1;
        end
        2'd2: begin
          if (m_hist.size() == DEPTH) void'(m_hist.pop_front());
          m_hist.push_back(m_acc);
          m_acc = m_acc - 2'd1;
        end
        2'd3: if (m_hist.size() > 0) m_acc = m_hist.pop_back();
        default: ;
      endcase
    end
    return m_acc;
  endfunction

  task automatic step(input string tag, input logic r,
                      input logic [1:0] op, input logic [1:0] exp);
    logic [1:0] mexp;
    @(negedge clk);
    rst = r;
    bus.x = op;
    mexp = model(r, op);
    sb.push_back(exp);
    @(posedge clk);
    #1;
    chk(tag, bus.result, sb.pop_front());
    if (mexp !== exp) begin
      n_fail++;
      $display("FAIL %s_plan model=%0d plan=%0d", tag, mexp, exp);
    end
  endtask

  task automatic rstep(input string tag, input logic r, input logic [1:0] op);
    logic [1:0] e;
    @(negedge clk);
    rst = r;
    bus.x = op;
    e = model(r, op);
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk(tag, bus.result, sb.pop_front());
  endtask

  initial begin
    bus.x = 2'b01;
    rst = 1'b1;
    // 1: reset held two cycles with INC presented
    step("rst0", 1'b1, 2'b01, 2'd0);
    step("rst1", 1'b1, 2'b01, 2'd0);
    step("rst_rel", 1'b0, 2'b00, 2'd0);
    // 2: wrap up then down
    step("up1", 1'b0, 2'b01, 2'd1);
    step("up2", 1'b0, 2'b01, 2'd2);
    step("up3", 1'b0, 2'b01, 2'd3);
    step("up4", 1'b0, 2'b01, 2'd0);
    step("dn_wrap", 1'b0, 2'b10, 2'd3);
    // 3: wrap down and undo to empty
    step("r3", 1'b1, 2'b00, 2'd0);
    step("dec1", 1'b0, 2'b10, 2'd3);
    step("dec2", 1'b0, 2'b10, 2'd2);
    step("undo1", 1'b0, 2'b11, 2'd3);
    step("undo2", 1'b0, 2'b11, 2'd0);
    step("undo_empty", 1'b0, 2'b11, 2'd0);
    // 4: overflow drops the oldest entry
    step("r4", 1'b1, 2'b00, 2'd0);
    step("ov_inc1", 1'b0, 2'b01, 2'd1);
    step("ov_inc2", 1'b0, 2'b01, 2'd2);
    step("ov_inc3", 1'b0, 2'b01, 2'd3);
    step("ov_inc4", 1'b0, 2'b01, 2'd0);
    step("ov_inc5", 1'b0, 2'b01, 2'd1);
    step("ov_un1", 1'b0, 2'b11, 2'd0);
    step("ov_un2", 1'b0, 2'b11, 2'd3);
    step("ov_un3", 1'b0, 2'b11, 2'd2);
    step("ov_un4", 1'b0, 2'b11, 2'd1);
    step("ov_un5", 1'b0, 2'b11, 2'd1);
    // 5: mixed with HOLD
    step("r5", 1'b1, 2'b00, 2'd0);
    step("mx_inc", 1'b0, 2'b01, 2'd1);
    step("mx_hold1", 1'b0, 2'b00, 2'd1);
    step("mx_hold2", 1'b0, 2'b00, 2'd1);
    step("mx_dec", 1'b0, 2'b10, 2'd0);
    step("mx_undo", 1'b0, 2'b11, 2'd1);
    // 6: reset mid-sequence clears history
    step("r6", 1'b1, 2'b00, 2'd0);
    step("mr_inc1", 1'b0, 2'b01, 2'd1);
    step("mr_inc2", 1'b0, 2'b01, 2'd2);
    step("mr_inc3", 1'b0, 2'b01, 2'd3);
    step("mr_rst", 1'b1, 2'b11, 2'd0);
    step("mr_undo", 1'b0, 2'b11, 2'd0);
    // Random mix with occasional resets
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic r;
      op = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 19) == 0);
      rstep("rand", r, op);
    end
    // Registered output must not follow x within a cycle
    @(negedge clk);
    rst = 1'b0;
    bus.x = 2'b00;
    @(posedge clk);
    #1;
    begin
      logic [1:0] held;
      held = m_acc;
      bus.x = 2'b01;
      #2;
      chk("no_comb", bus.result, held);
      bus.x = 2'b00;
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
